// File: rtl/mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// mem_bus_bridge
//
// Moves words between the shared tri-state DATA bus and an external
// single-port memory. An address latch is loaded from the bus. Each access
// is a request/ready cycle through IDLE -> ACCESS -> FINISH. Read results
// are held in a latch and driven onto DATA whenever RD_OE is high.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS after TIMEOUT
// cycles without MEM_READY. The abort reports ERR together with DONE, and a
// timed-out read loads all-ones into the read latch. Without the macro,
// ACCESS waits for MEM_READY indefinitely and ERR is tied low.
//
// Parameters
//   BUS_WIDTH   width of DATA, MEM_WDATA, MEM_RDATA
//   ADDR_WIDTH  width of the address latch / MEM_ADDR (<= BUS_WIDTH)
//   TIMEOUT     ACCESS cycle limit (MEM_TIMEOUT_EN only)
//
// Ports
//   CLOCK      rising-edge clock
//   RESET      synchronous, active-high reset
//   DATA       shared bidirectional processor bus
//   ADDR_LOAD  load DATA[ADDR_WIDTH-1:0] into the address latch (IDLE only)
//   START      begin a memory cycle (IDLE only, ignored when ADDR_LOAD is high)
//   OP         0 = memory read, 1 = memory write
//   AUTO_INC   increment the address when this cycle completes
//   RD_OE      drive the read latch onto DATA
//   BUSY       access in progress
//   DONE       one-cycle completion pulse
//   ERR        one-cycle timeout pulse (coincides with DONE)
//   MEM_ADDR   memory address (the address latch)
//   MEM_WDATA  write data latch
//   MEM_RDATA  memory read data
//   MEM_CS     memory chip select
//   MEM_WE     memory write enable
//   MEM_READY  memory completion strobe
// ---------------------------------------------------------------------------
module mem_bus_bridge #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  inout  wire  [BUS_WIDTH-1:0]  DATA,
  input  logic                  ADDR_LOAD,
  input  logic                  START,
  input  logic                  OP,
  input  logic                  AUTO_INC,
  input  logic                  RD_OE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [BUS_WIDTH-1:0]  MEM_WDATA,
  input  logic [BUS_WIDTH-1:0]  MEM_RDATA,
  output logic                  MEM_CS,
  output logic                  MEM_WE,
  input  logic                  MEM_READY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // Reject impossible configurations at elaboration time.
  if (ADDR_WIDTH > BUS_WIDTH || TIMEOUT < 1) begin : g_bad_params
    $error("mem_bus_bridge: need ADDR_WIDTH <= BUS_WIDTH and TIMEOUT >= 1");
  end

  logic [1:0]           state;
  logic                 op_q;      // captured OP for the access in flight
  logic                 inc_q;     // captured AUTO_INC for the access in flight
  logic [BUS_WIDTH-1:0] rd_latch;

  // Read latch drives the shared bus only on request, in any state.
  assign DATA = RD_OE ? rd_latch : {BUS_WIDTH{1'bz}};

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;   // completed ACCESS cycles without MEM_READY
`else
  assign ERR = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values; mixing in blocking writes here would make the
  // result depend on statement order.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      op_q      <= 1'b0;
      inc_q     <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      rd_latch  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      MEM_CS    <= 1'b0;
      MEM_WE    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      ERR       <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // ADDR_LOAD has priority: a simultaneous START is dropped.
          if (ADDR_LOAD) begin
            MEM_ADDR <= DATA[ADDR_WIDTH-1:0];
          end else if (START) begin
            state  <= ACCESS;
            op_q   <= OP;
            inc_q  <= AUTO_INC;
            BUSY   <= 1'b1;
            MEM_CS <= 1'b1;
            MEM_WE <= OP;
            if (OP) MEM_WDATA <= DATA;
`ifdef MEM_TIMEOUT_EN
            cnt    <= '0;
`endif
          end
        end

        ACCESS: begin
          if (MEM_READY) begin
            state  <= FINISH;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            MEM_CS <= 1'b0;
            MEM_WE <= 1'b0;
            if (!op_q) rd_latch <= MEM_RDATA;
          end
`ifdef MEM_TIMEOUT_EN
          // cnt == TIMEOUT-1 means this is the TIMEOUT-th ACCESS cycle.
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state  <= FINISH;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            ERR    <= 1'b1;
            MEM_CS <= 1'b0;
            MEM_WE <= 1'b0;
            if (!op_q) rd_latch <= {BUS_WIDTH{1'b1}};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end

        FINISH: begin
          state <= IDLE;
          DONE  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          ERR   <= 1'b0;
`endif
          // Natural wrap of the adder gives all-ones -> 0.
          if (inc_q) MEM_ADDR <= MEM_ADDR + ADDR_WIDTH'(1);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_bridge
//
// Self-checking bench for mem_bus_bridge. A table of transactions (address,
// op, auto-increment, write data, memory read data, wait states, expected
// read latch and final address) is applied in a loop; the expected outcome
// of each access is pushed to a scoreboard queue when START is driven and
// popped when DONE appears. Hand-written sequences cover reset, ADDR_LOAD/
// START conflicts, START during ACCESS, and MEM_READY held low (timeout when
// MEM_TIMEOUT_EN is defined, indefinite wait otherwise), followed by a reset
// in the middle of an access.
// ---------------------------------------------------------------------------
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        addr_load, start, op, auto_inc, rd_oe, mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] data_drv;
  logic        data_oe;
  wire  [15:0] data_bus;
  logic        busy, done, err, mem_cs, mem_we;
  logic [15:0] mem_addr, mem_wdata;

  assign data_bus = data_oe ? data_drv : 16'hzzzz;

  mem_bus_bridge #(
    .BUS_WIDTH (16),
    .ADDR_WIDTH(16),
    .TIMEOUT   (15)
  ) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .DATA     (data_bus),
    .ADDR_LOAD(addr_load),
    .START    (start),
    .OP       (op),
    .AUTO_INC (auto_inc),
    .RD_OE    (rd_oe),
    .BUSY     (busy),
    .DONE     (done),
    .ERR      (err),
    .MEM_ADDR (mem_addr),
    .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata),
    .MEM_CS   (mem_cs),
    .MEM_WE   (mem_we),
    .MEM_READY(mem_ready)
  );

  typedef struct {
    logic [15:0] addr;
    logic        op;
    logic        inc;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          waits;
    logic [15:0] exp_rd;
    logic [15:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [15:0] rd;
    logic [15:0] addr;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_latch(output logic [15:0] v);
    data_oe = 1'b0;
    rd_oe   = 1'b1;
    #1;
    v     = data_bus;
    rd_oe = 1'b0;
    #1;
  endtask

  // Runs ACCESS cycles until DONE or budget. MEM_READY is raised in ACCESS
  // cycle (ready_after+1); ready_after < 0 keeps it low. lat counts cycles
  // from the START edge.
  task automatic wait_done(input int ready_after, input logic exp_op,
                           input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                           input int budget, input string tag,
                           output int lat, output bit seen);
    lat  = 1;
    seen = 1'b0;
    while (lat < budget) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({tag, " access cs"},   mem_cs,   1);
      check({tag, " access we"},   mem_we,   exp_op);
      check({tag, " access busy"}, busy,     1);
      check({tag, " access err"},  err,      0);
      check({tag, " access addr"}, mem_addr, exp_addr);
      if (exp_op) check({tag, " access wdata"}, mem_wdata, exp_wdata);
      mem_ready = (ready_after >= 0) && (lat - 1 == ready_after);
      step();
      lat++;
    end
    mem_ready = 1'b0;
  endtask

  // Called in the FINISH cycle: pop the scoreboard and compare.
  task automatic finish_checks(input string tag, input int lat);
    exp_t        e;
    logic [15:0] v;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, " latency"},     lat,    e.lat);
    check({tag, " done"},        done,   1);
    check({tag, " err"},         err,    e.err);
    check({tag, " finish busy"}, busy,   0);
    check({tag, " finish cs"},   mem_cs, 0);
    check({tag, " finish we"},   mem_we, 0);
    read_latch(v);
    check({tag, " read latch"},  v,      e.rd);
    start = 1'b0;
    step();
    check({tag, " done pulse"},  done,     0);
    check({tag, " err pulse"},   err,      0);
    check({tag, " final addr"},  mem_addr, e.addr);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    data_oe   = 1'b1;
    data_drv  = v.addr;
    addr_load = 1'b1;
    step();
    addr_load = 1'b0;
    check({tag, " addr load"}, mem_addr, v.addr);
    data_drv  = v.wdata;
    start     = 1'b1;
    op        = v.op;
    auto_inc  = v.inc;
    mem_rdata = v.rdata;
    mem_ready = 1'b0;
    e.rd   = v.exp_rd;
    e.addr = v.exp_addr;
    e.err  = 1'b0;
    e.lat  = v.waits + 2;
    sb.push_back(e);
    step();
    start   = 1'b0;
    data_oe = 1'b0;
    wait_done(v.waits, v.op, v.addr, v.wdata, 40, tag, lat, seen);
    check({tag, " done seen"}, seen, 1);
    if (seen) finish_checks(tag, lat);
    else void'(sb.pop_front());
  endtask

  task automatic reset_mid_access();
    logic [15:0] v;
    check("pre-reset in access", mem_cs, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid reset busy", busy,     0);
    check("mid reset cs",   mem_cs,   0);
    check("mid reset we",   mem_we,   0);
    check("mid reset done", done,     0);
    check("mid reset addr", mem_addr, 16'h0000);
    data_oe  = 1'b1;
    data_drv = 16'h5A5A;
    rd_oe    = 1'b0;
    #1;
    check("mid reset bus released", data_bus, 16'h5A5A);
    read_latch(v);
    check("mid reset read latch", v, 16'h0000);
    step();
    check("mid reset stays idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int          lat;
    bit          seen;
    exp_t        e;

    //           addr      op    inc   wdata     rdata     w  exp_rd    exp_addr
    vecs[0] = '{16'h0040, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 16'h0040};
    vecs[1] = '{16'h0100, 1'b1, 1'b0, 16'h1234, 16'hDEAD, 3, 16'hBEEF, 16'h0100};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'h0F0F, 1, 16'h0F0F, 16'h0000};
    vecs[3] = '{16'h1234, 1'b1, 1'b1, 16'hA5A5, 16'h1111, 2, 16'h0F0F, 16'h1235};
    vecs[4] = '{16'h7FFF, 1'b0, 1'b1, 16'h0000, 16'h0000, 0, 16'h0000, 16'h8000};
    vecs[5] = '{16'hABCD, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 5, 16'hFFFE, 16'hABCD};

    rst = 1'b1; addr_load = 1'b0; start = 1'b0; op = 1'b0; auto_inc = 1'b0;
    rd_oe = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0; data_drv = 16'h0; data_oe = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset busy",  busy,      0);
    check("reset done",  done,      0);
    check("reset err",   err,       0);
    check("reset cs",    mem_cs,    0);
    check("reset we",    mem_we,    0);
    check("reset addr",  mem_addr,  16'h0000);
    check("reset wdata", mem_wdata, 16'h0000);
    read_latch(v);
    check("reset read latch", v, 16'h0000);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // ADDR_LOAD and START together: address loads, no access starts.
    data_oe = 1'b1; data_drv = 16'h2222; addr_load = 1'b1; start = 1'b1; op = 1'b0;
    step();
    addr_load = 1'b0; start = 1'b0; data_oe = 1'b0;
    check("conflict addr",  mem_addr, 16'h2222);
    check("conflict busy",  busy,     0);
    check("conflict cs",    mem_cs,   0);
    step();
    check("conflict still idle", mem_cs, 0);

    // START held high through ACCESS: only one completion.
    start = 1'b1; op = 1'b0; auto_inc = 1'b0; mem_rdata = 16'h3333;
    e.rd = 16'h3333; e.addr = 16'h2222; e.err = 1'b0; e.lat = 4;
    sb.push_back(e);
    step();
    wait_done(2, 1'b0, 16'h2222, 16'h0000, 40, "start in access", lat, seen);
    check("start in access done seen", seen, 1);
    if (seen) finish_checks("start in access", lat);
    for (int k = 0; k < 3; k++) begin
      check("start in access no 2nd busy", busy, 0);
      check("start in access no 2nd done", done, 0);
      step();
    end

    // MEM_READY held low.
    data_oe = 1'b1; data_drv = 16'h00FF; addr_load = 1'b1;
    step();
    addr_load = 1'b0; data_oe = 1'b0;
    start = 1'b1; op = 1'b0; auto_inc = 1'b1; mem_rdata = 16'h4444;
`ifdef MEM_TIMEOUT_EN
    e.rd = 16'hFFFF; e.addr = 16'h0100; e.err = 1'b1; e.lat = 16;
    sb.push_back(e);
    step();
    start = 1'b0;
    wait_done(-1, 1'b0, 16'h00FF, 16'h0000, 40, "timeout", lat, seen);
    check("timeout done seen", seen, 1);
    if (seen) finish_checks("timeout", lat);
    start = 1'b1; op = 1'b0; auto_inc = 1'b0;
    step();
    start = 1'b0;
    step();
`else
    step();
    start = 1'b0;
    wait_done(-1, 1'b0, 16'h00FF, 16'h0000, 20, "no timeout", lat, seen);
    check("no timeout no done", seen, 0);
    check("no timeout busy",    busy, 1);
    check("no timeout err",     err,  0);
`endif
    reset_mid_access();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
